// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch front end. It owns the program counter and issues one
// instruction memory request at a time. It holds the returned instruction for
// decode until the controller lets the PC advance. A redirect (br_taken with
// enable_updatePC) that arrives while a request is still outstanding moves the
// PC immediately. The in-flight response is then drained and dropped, so the
// stale instruction never reaches decode.
//
// Ports
//   clk             in   pipeline clock, rising edge
//   rst             in   synchronous active-high reset
//   enable_updatePC in   controller permission to advance / redirect the PC
//   enable_fetch    in   controller permission to start a new fetch
//   br_taken        in   redirect qualifier: PC loads taddr instead of pc+1
//   taddr[15:0]     in   branch / jump target
//   imem_req        out  memory request, held until imem_ack
//   imem_addr[15:0] out  memory address, stable while imem_req is high
//   imem_ack        in   one-cycle response strobe
//   imem_rdata[15:0]in   instruction word, valid with imem_ack
//   pc[15:0]        out  current fetch PC
//   npc[15:0]       out  pc+1 (combinational, wraps modulo 2^16)
//   IMem_dout[15:0] out  captured instruction
//   instr_valid     out  IMem_dout holds an unconsumed instruction
//   complete_instr  out  one-cycle pulse when a fetch completes
// -----------------------------------------------------------------------------
module fetch_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable_updatePC,
    input  logic        enable_fetch,
    input  logic        br_taken,
    input  logic [15:0] taddr,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_rdata,
    output logic [15:0] pc,
    output logic [15:0] npc,
    output logic [15:0] IMem_dout,
    output logic        instr_valid,
    output logic        complete_instr
);

    localparam logic [15:0] RESET_PC = 16'h3000;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        HOLD    = 2'd2,
        DISCARD = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic        imem_req_q, imem_req_d;
    logic [15:0] imem_addr_q, imem_addr_d;
    logic [15:0] dout_q, dout_d;
    logic        instr_valid_q, instr_valid_d;
    logic        complete_q, complete_d;

    logic [15:0] pc_inc;
    logic        redirect;

    // Natural 16-bit wrap gives the modulo-2^16 behaviour for FFFF -> 0000.
    assign pc_inc   = pc_q + 16'd1;
    assign redirect = enable_updatePC & br_taken;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        imem_req_d    = imem_req_q;
        imem_addr_d   = imem_addr_q;
        dout_d        = dout_q;
        instr_valid_d = instr_valid_q;
        complete_d    = 1'b0;

        case (state_q)
            IDLE: begin
                // Any ack seen here belongs to an abandoned request and is ignored.
                if (enable_updatePC) begin
                    pc_d = br_taken ? taddr : pc_inc;
                end
                if (enable_fetch) begin
                    imem_req_d  = 1'b1;
                    imem_addr_d = pc_q;
                    state_d     = REQ;
                end
            end

            REQ: begin
                if (imem_ack) begin
                    imem_req_d = 1'b0;
                    if (redirect) begin
                        // Response raced the redirect: it is for the old path.
                        pc_d    = taddr;
                        state_d = IDLE;
                    end else begin
                        dout_d        = imem_rdata;
                        instr_valid_d = 1'b1;
                        complete_d    = 1'b1;
                        state_d       = HOLD;
                    end
                end else if (redirect) begin
                    // Keep the request and its address stable until the memory
                    // answers, then throw the answer away.
                    pc_d    = taddr;
                    state_d = DISCARD;
                end
                // A plain advance (no br_taken) while fetching is ignored.
            end

            HOLD: begin
                if (enable_updatePC) begin
                    pc_d          = br_taken ? taddr : pc_inc;
                    instr_valid_d = 1'b0;
                    state_d       = IDLE;
                end
            end

            DISCARD: begin
                // A further redirect while draining still wins the PC.
                if (redirect) begin
                    pc_d = taddr;
                end
                if (imem_ack) begin
                    imem_req_d = 1'b0;
                    state_d    = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC;
            imem_req_q    <= 1'b0;
            imem_addr_q   <= RESET_PC;
            dout_q        <= 16'h0000;
            instr_valid_q <= 1'b0;
            complete_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            imem_req_q    <= imem_req_d;
            imem_addr_q   <= imem_addr_d;
            dout_q        <= dout_d;
            instr_valid_q <= instr_valid_d;
            complete_q    <= complete_d;
        end
    end

    assign pc             = pc_q;
    assign npc            = pc_inc;
    assign imem_req       = imem_req_q;
    assign imem_addr      = imem_addr_q;
    assign IMem_dout      = dout_q;
    assign instr_valid    = instr_valid_q;
    assign complete_instr = complete_q;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic        enable_updatePC;
    logic        enable_fetch;
    logic        br_taken;
    logic [15:0] taddr;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic [15:0] pc;
    logic [15:0] npc;
    logic [15:0] IMem_dout;
    logic        instr_valid;
    logic        complete_instr;

    int n_cmp;
    int n_bad;

    fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .enable_updatePC(enable_updatePC),
        .enable_fetch   (enable_fetch),
        .br_taken       (br_taken),
        .taddr          (taddr),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .pc             (pc),
        .npc            (npc),
        .IMem_dout      (IMem_dout),
        .instr_valid    (instr_valid),
        .complete_instr (complete_instr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        enable_updatePC = 1'b0;
        enable_fetch    = 1'b0;
        br_taken        = 1'b0;
        taddr           = 16'h0000;
        imem_ack        = 1'b0;
        imem_rdata      = 16'h0000;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst   = 1'b1;
        idle_inputs();
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        check_eq("rst_pc",       pc,                    16'h3000);
        check_eq("rst_npc",      npc,                   16'h3001);
        check_eq("rst_addr",     imem_addr,             16'h3000);
        check_eq("rst_req",      {15'd0, imem_req},     16'd0);
        check_eq("rst_valid",    {15'd0, instr_valid},  16'd0);
        check_eq("rst_complete", {15'd0, complete_instr}, 16'd0);
        check_eq("rst_dout",     IMem_dout,             16'h0000);

        // IDLE without enable_fetch stays quiet
        tick();
        check_eq("idle_noreq", {15'd0, imem_req}, 16'd0);

        // First fetch: request held for 3 cycles, ack with 1261
        enable_fetch = 1'b1;
        tick();
        enable_fetch = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_eq("f1_req",  {15'd0, imem_req}, 16'd1);
            check_eq("f1_addr", imem_addr,         16'h3000);
            if (i < 2) tick();
        end
        imem_ack   = 1'b1;
        imem_rdata = 16'h1261;
        tick();
        imem_ack   = 1'b0;
        imem_rdata = 16'h0000;
        check_eq("f1_dout",     IMem_dout,               16'h1261);
        check_eq("f1_valid",    {15'd0, instr_valid},    16'd1);
        check_eq("f1_complete", {15'd0, complete_instr}, 16'd1);
        check_eq("f1_req_drop", {15'd0, imem_req},       16'd0);

        // Stall in HOLD for 5 cycles
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq("stall_dout",     IMem_dout,               16'h1261);
            check_eq("stall_pc",       pc,                      16'h3000);
            check_eq("stall_valid",    {15'd0, instr_valid},    16'd1);
            check_eq("stall_req",      {15'd0, imem_req},       16'd0);
            check_eq("stall_complete", {15'd0, complete_instr}, 16'd0);
        end

        // Sequential advance, then fetch at 3001
        enable_updatePC = 1'b1;
        tick();
        enable_updatePC = 1'b0;
        check_eq("adv_pc",    pc,                   16'h3001);
        check_eq("adv_valid", {15'd0, instr_valid}, 16'd0);
        enable_fetch = 1'b1;
        tick();
        enable_fetch = 1'b0;
        check_eq("f2_addr", imem_addr,         16'h3001);
        check_eq("f2_req",  {15'd0, imem_req}, 16'd1);
        imem_ack   = 1'b1;
        imem_rdata = 16'hABCD;
        tick();
        imem_ack = 1'b0;
        check_eq("f2_dout",     IMem_dout,               16'hABCD);
        check_eq("f2_complete", {15'd0, complete_instr}, 16'd1);

        // Taken branch from HOLD to 3050
        enable_updatePC = 1'b1;
        br_taken        = 1'b1;
        taddr           = 16'h3050;
        tick();
        idle_inputs();
        check_eq("br_pc", pc, 16'h3050);
        enable_fetch = 1'b1;
        tick();
        enable_fetch = 1'b0;
        check_eq("br_addr", imem_addr, 16'h3050);

        // Redirect to 4000 while request pending; ack FFFF two cycles later
        enable_updatePC = 1'b1;
        br_taken        = 1'b1;
        taddr           = 16'h4000;
        tick();
        idle_inputs();
        check_eq("rd_pc",       pc,                16'h4000);
        check_eq("rd_req_held", {15'd0, imem_req}, 16'd1);
        check_eq("rd_addr_old", imem_addr,         16'h3050);
        tick();
        check_eq("rd_addr_old2", imem_addr, 16'h3050);
        imem_ack   = 1'b1;
        imem_rdata = 16'hFFFF;
        tick();
        imem_ack = 1'b0;
        check_eq("rd_no_complete", {15'd0, complete_instr}, 16'd0);
        check_eq("rd_dout_keep",   IMem_dout,               16'hABCD);
        check_eq("rd_valid",       {15'd0, instr_valid},    16'd0);
        check_eq("rd_req_drop",    {15'd0, imem_req},       16'd0);
        enable_fetch = 1'b1;
        tick();
        enable_fetch = 1'b0;
        check_eq("rd_next_addr", imem_addr, 16'h4000);
        imem_ack   = 1'b1;
        imem_rdata = 16'h1111;
        tick();
        imem_ack = 1'b0;
        check_eq("f4_dout", IMem_dout, 16'h1111);

        // Branch to FFFF, then wrap-around advance from IDLE
        enable_updatePC = 1'b1;
        br_taken        = 1'b1;
        taddr           = 16'hFFFF;
        tick();
        idle_inputs();
        check_eq("wrap_pc_ffff", pc,  16'hFFFF);
        check_eq("wrap_npc_0",   npc, 16'h0000);
        enable_updatePC = 1'b1;
        tick();
        enable_updatePC = 1'b0;
        check_eq("wrap_pc_0",   pc,  16'h0000);
        check_eq("wrap_npc_1",  npc, 16'h0001);

        // Redirect and ack in the same cycle
        enable_fetch = 1'b1;
        tick();
        enable_fetch = 1'b0;
        check_eq("race_addr", imem_addr, 16'h0000);
        enable_updatePC = 1'b1;
        br_taken        = 1'b1;
        taddr           = 16'h5000;
        imem_ack        = 1'b1;
        imem_rdata      = 16'h2222;
        tick();
        idle_inputs();
        check_eq("race_pc",       pc,                      16'h5000);
        check_eq("race_complete", {15'd0, complete_instr}, 16'd0);
        check_eq("race_valid",    {15'd0, instr_valid},    16'd0);
        check_eq("race_dout",     IMem_dout,               16'h1111);
        check_eq("race_req",      {15'd0, imem_req},       16'd0);

        // Plain advance while fetching is ignored
        enable_fetch = 1'b1;
        tick();
        enable_fetch    = 1'b0;
        enable_updatePC = 1'b1;
        tick();
        enable_updatePC = 1'b0;
        check_eq("req_adv_pc",  pc,                16'h5000);
        check_eq("req_adv_req", {15'd0, imem_req}, 16'd1);

        // Reset mid-request, then a late ack is ignored
        rst = 1'b1;
        imem_ack   = 1'b1;
        imem_rdata = 16'h3333;
        tick();
        rst = 1'b0;
        check_eq("mrst_pc",   pc,                16'h3000);
        check_eq("mrst_req",  {15'd0, imem_req}, 16'd0);
        check_eq("mrst_addr", imem_addr,         16'h3000);
        check_eq("mrst_dout", IMem_dout,         16'h0000);
        tick();
        imem_ack = 1'b0;
        check_eq("late_valid",    {15'd0, instr_valid},    16'd0);
        check_eq("late_complete", {15'd0, complete_instr}, 16'd0);
        check_eq("late_dout",     IMem_dout,               16'h0000);
        check_eq("late_req",      {15'd0, imem_req},       16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
